// File: rtl/mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator
// Brief    : Registered multiply-accumulate stage with valid/ready handshake,
//            guarded accumulator, sticky overflow and saturating op counter.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] plow,
    input  logic [WIDTH-1:0] phigh,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] c_op_load  = 2'b00;
    localparam logic [1:0] c_op_add   = 2'b01;
    localparam logic [1:0] c_op_sub   = 2'b10;
    localparam logic [1:0] c_op_clear = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_count;

    logic             w_xfer;
    logic [ACC_W-1:0] w_prod;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_diff;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    generate
        if (ACC_W > 2*WIDTH) begin : g_prod_guard
            assign w_prod = {{(ACC_W-2*WIDTH){1'b0}}, phigh, plow};
        end else begin : g_prod_exact
            assign w_prod = {phigh, plow};
        end
    endgenerate

    assign in_ready  = (r_state == S_EMPTY) | out_ready;
    assign w_xfer    = in_valid & in_ready;
    assign out_valid = (r_state == S_FULL);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;
    assign count     = r_count;

    // The extra top bit of each result is the carry (add) or borrow (sub).
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_prod};
    assign w_diff    = {1'b0, r_acc} - {1'b0, w_prod};
    assign w_cnt_inc = (r_count == c_cnt_max) ? r_count : r_count + CNT_W'(1);

    always_comb begin
        w_acc_nxt   = '0;
        w_ovf_nxt   = 1'b0;
        w_count_nxt = '0;
        case (op)
            c_op_load: begin
                w_acc_nxt = w_prod;
            end
            c_op_add: begin
                w_acc_nxt   = w_sum[ACC_W-1:0];
                w_ovf_nxt   = r_ovf | w_sum[ACC_W];
                w_count_nxt = w_cnt_inc;
            end
            c_op_sub: begin
                w_acc_nxt   = w_diff[ACC_W-1:0];
                w_ovf_nxt   = r_ovf | w_diff[ACC_W];
                w_count_nxt = w_cnt_inc;
            end
            c_op_clear: begin
                w_acc_nxt = '0;
            end
            default: begin
                w_acc_nxt = '0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_xfer) w_state_nxt = S_FULL;
            end
            S_FULL: begin
                if (!w_xfer && out_ready) w_state_nxt = S_EMPTY;
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operands are only sampled on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_xfer) begin
            r_acc   <= w_acc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator
// Brief    : Directed and model-checked bench for mac_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator;

    localparam logic [1:0] c_load  = 2'b00;
    localparam logic [1:0] c_add   = 2'b01;
    localparam logic [1:0] c_sub   = 2'b10;
    localparam logic [1:0] c_clear = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] plow;
    logic [15:0] phigh;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] acc_out;
    logic        ovf;
    logic [7:0]  count;

    int vec;
    int miscomp;

    mac_accumulator #(.WIDTH(16), .ACC_W(40), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .plow      (plow),
        .phigh     (phigh),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transfer: present at negedge, wait (bounded) for in_ready, take the edge.
    task automatic send(input logic [1:0] o, input logic [31:0] p);
        int waited;
        @(negedge clk);
        op       = o;
        {phigh, plow} = p;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            vec++;
            miscomp++;
            $display("FAIL send_ready: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        send(c_load, 32'd49);
        out_ready = 1'b0;
        vec++;
        if (out_valid !== 1'b1 || acc_out !== 40'd49) begin
            miscomp++;
            $display("FAIL reset_pre: out_valid=%0b acc=%0d required 1 49", out_valid, acc_out);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vec++;
        if (acc_out !== 40'd0 || ovf !== 1'b0 || count !== 8'd0 || out_valid !== 1'b0) begin
            miscomp++;
            $display("FAIL reset_async: acc=%0d ovf=%0b count=%0d out_valid=%0b required 0 0 0 0",
                     acc_out, ovf, count, out_valid);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_accumulate();
        logic [39:0] exp_acc [3];
        logic [7:0]  exp_cnt [3];
        logic [1:0]  ops     [3];
        logic [31:0] prods   [3];
        exp_acc = '{40'd12, 40'd42, 40'd4294836267};
        exp_cnt = '{8'd0, 8'd1, 8'd2};
        ops     = '{c_load, c_add, c_add};
        prods   = '{32'd12, 32'd30, 32'd4294836225};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], prods[i]);
            vec++;
            if (acc_out !== exp_acc[i] || count !== exp_cnt[i] || ovf !== 1'b0 || out_valid !== 1'b1) begin
                miscomp++;
                $display("FAIL accumulate[%0d]: acc=%0d count=%0d ovf=%0b ov=%0b required %0d %0d 0 1",
                         i, acc_out, count, ovf, out_valid, exp_acc[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_underflow();
        send(c_load, 32'd6);
        send(c_sub, 32'd16);
        vec++;
        if (acc_out !== 40'hFF_FFFF_FFF6 || ovf !== 1'b1 || count !== 8'd1) begin
            miscomp++;
            $display("FAIL underflow_sub: acc=%0h ovf=%0b count=%0d required fffffffff6 1 1",
                     acc_out, ovf, count);
        end
        send(c_add, 32'd10);
        vec++;
        if (acc_out !== 40'd0 || ovf !== 1'b1 || count !== 8'd2) begin
            miscomp++;
            $display("FAIL underflow_sticky: acc=%0d ovf=%0b count=%0d required 0 1 2",
                     acc_out, ovf, count);
        end
        send(c_load, 32'd25);
        vec++;
        if (acc_out !== 40'd25 || ovf !== 1'b0 || count !== 8'd0) begin
            miscomp++;
            $display("FAIL underflow_load: acc=%0d ovf=%0b count=%0d required 25 0 0",
                     acc_out, ovf, count);
        end
    endtask

    task automatic test_backpressure();
        send(c_load, 32'd100);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = c_add;
        {phigh, plow} = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++;
            if (in_ready !== 1'b0) begin
                miscomp++;
                $display("FAIL bp_ready[%0d]: in_ready=%0b required 0", i, in_ready);
            end
            @(posedge clk);
            #1;
            vec++;
            if (acc_out !== 40'd100 || out_valid !== 1'b1 || count !== 8'd0) begin
                miscomp++;
                $display("FAIL bp_hold[%0d]: acc=%0d ov=%0b count=%0d required 100 1 0",
                         i, acc_out, out_valid, count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vec++;
            if (acc_out !== 40'(101 + i) || count !== 8'(1 + i) || out_valid !== 1'b1) begin
                miscomp++;
                $display("FAIL bp_release[%0d]: acc=%0d count=%0d ov=%0b required %0d %0d 1",
                         i, acc_out, count, out_valid, 101 + i, 1 + i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        vec++;
        if (out_valid !== 1'b0 || acc_out !== 40'd103 || count !== 8'd3) begin
            miscomp++;
            $display("FAIL bp_drain: ov=%0b acc=%0d count=%0d required 0 103 3",
                     out_valid, acc_out, count);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        send(c_clear, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = c_add;
        {phigh, plow} = 32'd1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            vec++;
            if (out_valid !== 1'b1 || acc_out !== 40'(i + 1) ||
                count !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1))) begin
                miscomp++;
                if (bad < 5)
                    $display("FAIL b2b[%0d]: ov=%0b acc=%0d count=%0d required 1 %0d %0d",
                             i, out_valid, acc_out, count, i + 1, (i + 1 > 255) ? 255 : i + 1);
                bad++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clear_random();
        logic [39:0] m_acc;
        logic        m_ovf;
        logic [7:0]  m_cnt;
        logic [40:0] t;
        logic [1:0]  o;
        logic [31:0] p;
        send(c_load, 32'd81);
        send(c_clear, {16'd5678, 16'd1234});
        vec++;
        if (acc_out !== 40'd0 || count !== 8'd0 || ovf !== 1'b0) begin
            miscomp++;
            $display("FAIL clear: acc=%0d count=%0d ovf=%0b required 0 0 0", acc_out, count, ovf);
        end
        m_acc = '0;
        m_ovf = 1'b0;
        m_cnt = '0;
        for (int i = 0; i < 200; i++) begin
            o = 2'($urandom_range(0, 3));
            if (o == c_clear && $urandom_range(0, 3) != 0) o = c_add;
            p = 32'($urandom_range(0, 65535)) * 32'($urandom_range(0, 65535));
            case (o)
                c_load:  begin m_acc = {8'd0, p}; m_ovf = 1'b0; m_cnt = '0; end
                c_add:   begin
                    t = {1'b0, m_acc} + {9'd0, p};
                    m_acc = t[39:0]; m_ovf = m_ovf | t[40];
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end
                c_sub:   begin
                    t = {1'b0, m_acc} - {9'd0, p};
                    m_acc = t[39:0]; m_ovf = m_ovf | t[40];
                    if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
                end
                default: begin m_acc = '0; m_ovf = 1'b0; m_cnt = '0; end
            endcase
            send(o, p);
            vec++;
            if (acc_out !== m_acc || ovf !== m_ovf || count !== m_cnt) begin
                miscomp++;
                $display("FAIL random[%0d] op=%0d: acc=%0h ovf=%0b count=%0d required %0h %0b %0d",
                         i, o, acc_out, ovf, count, m_acc, m_ovf, m_cnt);
            end
        end
    endtask

    initial begin
        vec       = 0;
        miscomp   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = c_load;
        plow      = '0;
        phigh     = '0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if (acc_out !== 40'd0 || ovf !== 1'b0 || count !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscomp++;
            $display("FAIL reset_init: acc=%0d ovf=%0b count=%0d ov=%0b ir=%0b required 0 0 0 0 1",
                     acc_out, ovf, count, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_accumulate();
        test_underflow();
        test_backpressure();
        test_back_to_back();
        test_clear_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
        $finish;
    end

endmodule
`default_nettype wire
